// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional
// even/odd parity bit, one stop bit. One serial bit per clk; all outputs registered.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  load;
   logic                  par_bit;

   // Parity comes from the latched payload; odd parity is the inverted XOR.
   assign par_bit = (^data_q) ^ ptyp_q;
   assign load    = data_valid && ((state_q == IDLE) || (state_q == STOP));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sh_d    = sh_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE, STOP: begin
            if (data_valid) begin
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = data_q[0];
            sh_d    = data_q >> 1;
            busy_d  = 1'b1;
         end
         DATA: begin
            busy_d = 1'b1;
            if (cnt_q == LAST) begin
               if (pen_q) begin
                  state_d = PARITY;
                  tx_d    = par_bit;
               end else begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               tx_d  = sh_q[0];
               sh_d  = sh_q >> 1;
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
            busy_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
      if (load) begin
         data_d = p_data;
         pen_d  = par_en;
         ptyp_d = par_typ;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         sh_q    <= '0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sh_q    <= sh_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_out = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected frames are built from the framing rules
// and queued on request; a negedge monitor checks every line cycle of two DUTs.
module tb_uart_tx;
   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       rst_s = 1'b0;
   logic [7:0] p_data = '0;
   logic       data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
   logic       tx_out, busy;
   logic [4:0] p5 = '0;
   logic       dv5 = 1'b0, pe5 = 1'b0, pt5 = 1'b0;
   logic       tx5, busy5;
   int         passed = 0, total = 0;

   typedef struct {
      logic [15:0] bits;
      int          len;
      bit          b2b;
   } frame_t;

   frame_t q8[$];
   frame_t q5[$];
   bit     infr[2];
   int     pos[2];
   frame_t cur[2];

   uart_tx #(.DATA_WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
   );

   uart_tx #(.DATA_WIDTH(5)) u_dut5 (
      .clk(clk), .rst(rst), .p_data(p5), .data_valid(dv5),
      .par_en(pe5), .par_typ(pt5), .tx_out(tx5), .busy(busy5)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rst_s <= rst;

   // Reference frame: 0, payload LSB first, optional parity, 1.
   function automatic frame_t mk(input logic [7:0] d, input int w, input bit pen,
                                 input bit typ, input bit b2b);
      frame_t f;
      bit     par;
      int     idx;
      f.bits    = '0;
      f.bits[0] = 1'b0;
      par       = typ;
      for (int i = 0; i < w; i++) begin
         f.bits[1+i] = d[i];
         par         = par ^ d[i];
      end
      idx = 1 + w;
      if (pen) begin
         f.bits[idx] = par;
         idx++;
      end
      f.bits[idx] = 1'b1;
      f.len       = idx + 1;
      f.b2b       = b2b;
      return f;
   endfunction

   function automatic int qsize(input int ch);
      return (ch == 0) ? q8.size() : q5.size();
   endfunction

   function automatic frame_t qpop(input int ch);
      if (ch == 0) return q8.pop_front();
      else         return q5.pop_front();
   endfunction

   function automatic bit qb2b(input int ch);
      return (ch == 0) ? q8[0].b2b : q5[0].b2b;
   endfunction

   task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s ch%0d t=%0t: got %0h, expected %0h", nm, ch, $time, act, exp);
   endtask

   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         logic txv, bv;
         txv = (ch == 0) ? tx_out : tx5;
         bv  = (ch == 0) ? busy : busy5;
         if (!rst_s) begin
            infr[ch] = 1'b0;
            chk("reset_tx", ch, 32'(txv), 32'd1);
            chk("reset_busy", ch, 32'(bv), 32'd0);
         end else begin
            if (!infr[ch]) begin
               if (bv === 1'b1) begin
                  if (qsize(ch) > 0) begin
                     cur[ch]  = qpop(ch);
                     infr[ch] = 1'b1;
                     pos[ch]  = 0;
                  end else begin
                     chk("unexpected_frame_busy", ch, 32'(bv), 32'd0);
                  end
               end else begin
                  chk("idle_tx", ch, 32'(txv), 32'd1);
               end
            end
            if (infr[ch]) begin
               chk($sformatf("frame_bit%0d", pos[ch]), ch, 32'(txv), 32'(cur[ch].bits[pos[ch]]));
               chk("frame_busy", ch, 32'(bv), 32'd1);
               pos[ch]++;
               if (pos[ch] == cur[ch].len) begin
                  infr[ch] = 1'b0;
                  if (qsize(ch) > 0 && qb2b(ch)) begin
                     cur[ch]  = qpop(ch);
                     infr[ch] = 1'b1;
                     pos[ch]  = 0;
                  end
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      data_valid = 1'b0;
      dv5        = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just before the edge that ends STOP; a following send is back-to-back.
   // mode 0: quiet inputs, 1: random noise during the frame, 2: request 0x3C in DATA.
   task automatic send(input int ch, input logic [7:0] d, input bit pen, input bit typ,
                       input bit b2b, input int mode);
      frame_t f;
      f = mk(d, (ch == 0) ? 8 : 5, pen, typ, b2b);
      if (ch == 0) begin
         q8.push_back(f);
         p_data = d; par_en = pen; par_typ = typ; data_valid = 1'b1;
      end else begin
         q5.push_back(f);
         p5 = d[4:0]; pe5 = pen; pt5 = typ; dv5 = 1'b1;
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      dv5        = 1'b0;
      for (int k = 1; k < f.len; k++) begin
         if (mode == 1) begin
            data_valid = 1'($urandom_range(0, 1));
            p_data     = 8'($urandom);
            par_en     = 1'($urandom_range(0, 1));
            par_typ    = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            data_valid = (k == 3);
            if (k == 3) p_data = 8'h3C;
         end
         @(posedge clk); #1;
      end
      data_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q8.size() != 0 || q5.size() != 0 || infr[0] || infr[1]) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (n >= 300) begin
         total++;
         $display("FAIL drain: frames still pending after %0d cycles, expected none", n);
      end
   endtask

   initial begin
      bit b2b;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0); idle(3);
      send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 0); idle(2);
      send(0, 8'hA5, 1'b1, 1'b1, 1'b0, 0); idle(2);
      send(0, 8'h07, 1'b1, 1'b0, 1'b0, 0); idle(2);

      send(0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
      send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 0); idle(3);

      send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 2); idle(15);
      p_data = 8'h00;

      // Abort 0xA5 while data bit 3 is on the line.
      q8.push_back(mk(8'hA5, 8, 1'b0, 1'b0, 1'b0));
      p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2);
      send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 0); idle(3);

      send(1, 8'b10011, 1'b1, 1'b1, 1'b0, 0); idle(3);
      send(1, 8'h0A, 1'b1, 1'b0, 1'b0, 0);
      send(1, 8'h1F, 1'b0, 1'b0, 1'b1, 0); idle(3);

      for (int i = 0; i < 40; i++) begin
         b2b = (i > 0) && ($urandom_range(0, 1) == 1);
         if (!b2b) idle($urandom_range(1, 3));
         send(0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              b2b, $urandom_range(0, 1));
      end
      idle(3);
      for (int i = 0; i < 6; i++) begin
         send(1, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0);
         idle($urandom_range(1, 2));
      end

      drain();
      idle(4);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
